bp_rom_param_streamer: RTL and testbench

- Parameter-initialised ROM (contents fixed at elaboration by a packed bit-vector parameter) plus a burst read engine.
- A client issues one request (start address, beat count, stride). The block then streams ROM entries out over a valid/ready interface, one per cycle, with modulo-els_p address wrap.
- Used for boot/config tables, microcode sequences and test-vector playback where the consumer can backpressure.

---
 rtl/bp_rom_param_pkg.sv | 25 ++
 rtl/bp_rom_param_addr_gen.sv | 48 ++++
 rtl/bp_rom_param_streamer.sv | 106 ++++++++++
 tb/tb_bp_rom_param_streamer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_rom_param_pkg.sv
// Shared types and helpers for the parameter-initialised ROM burst streamer.
// Holds the FSM state encoding and the modulo address step used by the address generator.
package bp_rom_param_pkg;

  typedef enum logic {
    e_rom_idle,
    e_rom_busy
  } rom_state_e;

  // Same rule as BSG_SAFE_CLOG2: never returns a zero width.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // One-step modulo increment; legal operands are both below els, so one subtraction suffices.
  function automatic int unsigned addr_wrap(input int unsigned addr,
                                            input int unsigned stride,
                                            input int unsigned els);
    int unsigned sum;
    sum = addr + stride;
    if (sum >= els) sum = sum - els;
    return sum;
  endfunction

endpackage

// File: rtl/bp_rom_param_addr_gen.sv
// Burst address generator: walks the ROM by a fixed stride with modulo-els_p wrap
// and tracks how many beats remain to be issued.
module bp_rom_param_addr_gen
  import bp_rom_param_pkg::*;
#(
  parameter int els_p     = 8,
  parameter int lg_els_lp = 3,
  parameter int lg_len_lp = 8
)(
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load,
  input  logic                 advance,
  input  logic [lg_els_lp-1:0] start,
  input  logic [lg_len_lp-1:0] len,
  input  logic [lg_els_lp-1:0] stride,
  output logic [lg_els_lp-1:0] addr,
  output logic                 is_last,
  output logic                 pending
);

  logic [lg_len_lp-1:0] remaining;
  logic [lg_els_lp-1:0] stride_r;
  logic [lg_els_lp-1:0] next_addr;

  assign next_addr = lg_els_lp'(addr_wrap(32'(addr), 32'(stride_r), els_p));
  assign is_last   = (remaining == '0);

  // pending stays high until the beat with remaining==0 has been handed to the output register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr      <= '0;
      remaining <= '0;
      stride_r  <= '0;
      pending   <= 1'b0;
    end else if (load) begin
      addr      <= start;
      remaining <= len;
      stride_r  <= stride;
      pending   <= 1'b1;
    end else if (advance) begin
      addr <= next_addr;
      if (is_last) pending <= 1'b0;
      else remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: rtl/bp_rom_param_streamer.sv
// ROM with contents fixed by a packed parameter, streamed out in strided bursts
// over a valid/ready interface at up to one beat per cycle.
module bp_rom_param_streamer
  import bp_rom_param_pkg::*;
#(
  parameter int                        width_p   = 8,
  parameter int                        els_p     = 8,
  parameter logic [width_p*els_p-1:0]  data_p    = '0,
  parameter int                        max_len_p = 256,
  localparam int                       lg_els_lp = safe_clog2(els_p),
  localparam int                       lg_len_lp = safe_clog2(max_len_p)
)(
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  output logic                 ready_and_o,
  input  logic [lg_els_lp-1:0] start_i,
  input  logic [lg_len_lp-1:0] len_i,
  input  logic [lg_els_lp-1:0] stride_i,
  output logic [width_p-1:0]   data_o,
  output logic                 v_o,
  input  logic                 ready_and_i,
  output logic                 last_o
);

  localparam logic [lg_els_lp:0] els_lv = (lg_els_lp + 1)'(els_p);

  rom_state_e            state_r, state_n;
  logic                  load_req;
  logic                  load_out;
  logic                  accept_last;
  logic [lg_els_lp-1:0]  cur_addr;
  logic                  is_last;
  logic                  pending;
  logic [width_p-1:0]    rom_data;

  assign ready_and_o = (state_r == e_rom_idle);
  assign load_req    = ready_and_o & v_i;
  assign accept_last = v_o & ready_and_i & last_o;
  assign load_out    = (state_r == e_rom_busy) & pending & (~v_o | ready_and_i);

  bp_rom_param_addr_gen #(
    .els_p     (els_p),
    .lg_els_lp (lg_els_lp),
    .lg_len_lp (lg_len_lp)
  ) addr_gen (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load      (load_req),
    .advance   (load_out),
    .start     (start_i),
    .len       (len_i),
    .stride    (stride_i),
    .addr      (cur_addr),
    .is_last   (is_last),
    .pending   (pending)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_rom_idle;
    else state_r <= state_n;
  end

  // A burst ends only when its final beat is taken by the consumer, not when it is issued.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_rom_idle: if (v_i) state_n = e_rom_busy;
      e_rom_busy: if (accept_last) state_n = e_rom_idle;
      default:    state_n = e_rom_idle;
    endcase
  end

  always_comb begin
    rom_data = '0;
    for (int i = 0; i < els_p; i++) begin
      if (cur_addr == lg_els_lp'(i)) rom_data = data_p[i*width_p +: width_p];
    end
  end

  // Reloading on the accepting cycle keeps one beat per cycle; otherwise the beat is held.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o <= '0;
      v_o    <= 1'b0;
      last_o <= 1'b0;
    end else if (load_out) begin
      data_o <= rom_data;
      v_o    <= 1'b1;
      last_o <= is_last;
    end else if (v_o & ready_and_i) begin
      v_o    <= 1'b0;
      last_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && load_req) begin
      assert ({1'b0, start_i} < els_lv)
        else $error("bp_rom_param_streamer: start_i beyond ROM size");
      assert ({1'b0, stride_i} < els_lv)
        else $error("bp_rom_param_streamer: stride_i beyond ROM size");
    end
  end

endmodule

// File: tb/tb_bp_rom_param_streamer.sv
// Self-checking bench for bp_rom_param_streamer: an 8-entry and a 5-entry ROM checked
// every cycle against a queue-based burst model, plus literal beat lists for directed cases.
module tb_bp_rom_param_streamer;

  localparam logic [63:0] rom8 = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
  localparam logic [39:0] rom5 = {8'h24, 8'h23, 8'h22, 8'h21, 8'h20};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v_i      [2];
  logic [2:0] start_i  [2];
  logic [7:0] len_i    [2];
  logic [2:0] stride_i [2];
  logic       ready_o  [2];
  logic [7:0] data_o   [2];
  logic       v_o      [2];
  logic       rdy      [2];
  logic       last_o   [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q  [2][$];
  logic [7:0] got_q  [2][$];
  logic [7:0] want_q [$];
  bit         busy_m [2];
  int         phase  [2];
  int         rdy_mode [2];
  bit         rdy_man  [2];

  always #5 clk = ~clk;

  bp_rom_param_streamer #(
    .width_p (8), .els_p (8), .data_p (rom8), .max_len_p (256)
  ) dut8 (
    .clk_i (clk), .reset_n_i (reset_n), .v_i (v_i[0]), .ready_and_o (ready_o[0]),
    .start_i (start_i[0]), .len_i (len_i[0]), .stride_i (stride_i[0]),
    .data_o (data_o[0]), .v_o (v_o[0]), .ready_and_i (rdy[0]), .last_o (last_o[0])
  );

  bp_rom_param_streamer #(
    .width_p (8), .els_p (5), .data_p (rom5), .max_len_p (256)
  ) dut5 (
    .clk_i (clk), .reset_n_i (reset_n), .v_i (v_i[1]), .ready_and_o (ready_o[1]),
    .start_i (start_i[1]), .len_i (len_i[1]), .stride_i (stride_i[1]),
    .data_o (data_o[1]), .v_o (v_o[1]), .ready_and_i (rdy[1]), .last_o (last_o[1])
  );

  function automatic int els_of(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic logic [7:0] rom_of(input int d, input int i);
    return ((d == 0) ? 8'h10 : 8'h20) + 8'(i);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request expands to its full beat list; the stream must be valid from
  // the second cycle after acceptance until the final beat is taken.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit exp_v;
      if (!reset_n) begin
        checkOutput($sformatf("dut%0d reset v_o", d), 32'(v_o[d]), 32'd0);
        checkOutput($sformatf("dut%0d reset last_o", d), 32'(last_o[d]), 32'd0);
        checkOutput($sformatf("dut%0d reset data_o", d), 32'(data_o[d]), 32'd0);
        checkOutput($sformatf("dut%0d reset ready", d), 32'(ready_o[d]), 32'd1);
        exp_q[d].delete();
        busy_m[d] = 1'b0;
        phase[d]  = 0;
      end else begin
        exp_v = busy_m[d] && (phase[d] >= 1) && (exp_q[d].size() > 0);
        checkOutput($sformatf("dut%0d ready_and_o", d), 32'(ready_o[d]), 32'(!busy_m[d]));
        checkOutput($sformatf("dut%0d v_o", d), 32'(v_o[d]), 32'(exp_v));
        if (exp_v && v_o[d]) begin
          checkOutput($sformatf("dut%0d data_o", d), 32'(data_o[d]), 32'(exp_q[d][0]));
          checkOutput($sformatf("dut%0d last_o", d), 32'(last_o[d]),
                      32'(exp_q[d].size() == 1));
        end
        if (busy_m[d]) phase[d]++;
        if (exp_v && v_o[d] && rdy[d]) begin
          got_q[d].push_back(data_o[d]);
          void'(exp_q[d].pop_front());
          if (exp_q[d].size() == 0) busy_m[d] = 1'b0;
        end
        if (v_i[d] && ready_o[d] && !busy_m[d]) begin
          for (int k = 0; k <= int'(len_i[d]); k++)
            exp_q[d].push_back(rom_of(d, (int'(start_i[d]) + k * int'(stride_i[d])) % els_of(d)));
          busy_m[d] = 1'b1;
          phase[d]  = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        case (rdy_mode[d])
          0:       rdy[d] = 1'b1;
          1:       rdy[d] = ($urandom_range(0, 3) != 0);
          default: rdy[d] = rdy_man[d];
        endcase
      end
    end
  end

  task automatic applyStimulus(input int d, input int s, input int l, input int st);
    int n;
    n = 0;
    v_i[d]      = 1'b1;
    start_i[d]  = 3'(s);
    len_i[d]    = 8'(l);
    stride_i[d] = 3'(st);
    @(negedge clk);
    while (!ready_o[d] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("dut%0d request accepted", d), 32'(ready_o[d]), 32'd1);
    @(posedge clk);
    #1;
    v_i[d] = 1'b0;
  endtask

  task automatic waitIdle(input int d);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy_m[d] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("dut%0d burst completes", d), 32'(busy_m[d]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkSeq(input int d, input string name);
    checkOutput({name, " beat count"}, 32'(got_q[d].size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < got_q[d].size(); i++)
      checkOutput($sformatf("%s beat %0d", name, i), 32'(got_q[d][i]), 32'(want_q[i]));
  endtask

  task automatic runBurst(input int d, input int s, input int l, input int st);
    got_q[d].delete();
    applyStimulus(d, s, l, st);
    waitIdle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      v_i[d] = 1'b0; start_i[d] = '0; len_i[d] = '0; stride_i[d] = '0;
      rdy[d] = 1'b1; rdy_mode[d] = 0; rdy_man[d] = 1'b1;
      busy_m[d] = 1'b0; phase[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    runBurst(0, 2, 3, 1);
    want_q = '{8'h12, 8'h13, 8'h14, 8'h15};
    checkSeq(0, "linear");

    runBurst(0, 6, 4, 3);
    want_q = '{8'h16, 8'h11, 8'h14, 8'h17, 8'h12};
    checkSeq(0, "wrap8");

    runBurst(1, 3, 3, 4);
    want_q = '{8'h23, 8'h22, 8'h21, 8'h20};
    checkSeq(1, "wrap5");

    rdy_mode[0] = 2;
    rdy_man[0]  = 1'b1;
    got_q[0].delete();
    applyStimulus(0, 0, 3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy_man[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy_man[0] = 1'b1;
    waitIdle(0);
    want_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    checkSeq(0, "backpressure");
    rdy_mode[0] = 0;

    got_q[0].delete();
    applyStimulus(0, 0, 3, 1);
    applyStimulus(0, 5, 0, 1);
    waitIdle(0);
    want_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h15};
    checkSeq(0, "request while busy");

    runBurst(0, 7, 2, 0);
    want_q = '{8'h17, 8'h17, 8'h17};
    checkSeq(0, "stride zero");

    got_q[0].delete();
    applyStimulus(0, 0, 3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("mid-burst reset v_o", 32'(v_o[0]), 32'd0);
    checkOutput("mid-burst reset ready", 32'(ready_o[0]), 32'd1);
    want_q = '{8'h10};
    checkSeq(0, "before reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    runBurst(0, 1, 0, 1);
    want_q = '{8'h11};
    checkSeq(0, "after reset");

    runBurst(0, 0, 255, 1);
    checkOutput("max length beat count", 32'(got_q[0].size()), 32'd256);
    if (got_q[0].size() == 256) begin
      checkOutput("max length first beat", 32'(got_q[0][0]), 32'h10);
      checkOutput("max length final beat", 32'(got_q[0][255]), 32'h17);
    end

    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    for (int i = 0; i < 30; i++) begin
      int d, s1, l1, t1, s2, l2, t2, total;
      d  = i % 2;
      s1 = $urandom_range(0, els_of(d) - 1);
      t1 = $urandom_range(0, els_of(d) - 1);
      l1 = $urandom_range(0, 12);
      total = l1 + 1;
      got_q[d].delete();
      applyStimulus(d, s1, l1, t1);
      if (i % 3 == 0) begin
        s2 = $urandom_range(0, els_of(d) - 1);
        t2 = $urandom_range(0, els_of(d) - 1);
        l2 = $urandom_range(0, 6);
        total += l2 + 1;
        applyStimulus(d, s2, l2, t2);
      end
      waitIdle(d);
      checkOutput($sformatf("random burst %0d beat count", i), 32'(got_q[d].size()), 32'(total));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("dut0 model drained", 32'(exp_q[0].size()), 32'd0);
    checkOutput("dut1 model drained", 32'(exp_q[1].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
